// File: rtl/mac_seq_pkg.sv
// Shared types and widths for the dot-product sequencer and its mac datapath.
// Widths are fixed by the 8x8 multiplier and 16-bit accumulator.
package mac_seq_pkg;
   localparam int MAC_DW = 8;
   localparam int MAC_AW = 16;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      RUN,
      DRAIN,
      DONE
   } state_t;
endpackage

// File: rtl/mac.sv
// Purpose: 8x8 multiply-accumulate into a 16-bit wrapping accumulator with per-add carry flag.
// Latency: acc/of reflect a*b one cycle after it is presented; accumulates every cycle.
// Backpressure: none; the caller zeroes a/b on idle cycles.
module mac
   import mac_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [MAC_DW-1:0] a,
   input  logic [MAC_DW-1:0] b,
   output logic [MAC_AW-1:0] acc,
   output logic              of
);
   logic [MAC_AW-1:0] acc_q, acc_d;
   logic              of_q, of_d;
   logic [2*MAC_DW-1:0] prod;
   logic [MAC_AW:0]     sum;

   assign prod = a * b;
   assign sum  = {1'b0, acc_q} + {1'b0, prod};

   always_comb begin
      acc_d = sum[MAC_AW-1:0];
      of_d  = sum[MAC_AW];
   end

   // Synchronous reset: it is driven from controller state, not a reset tree.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         of_q  <= 1'b0;
      end else begin
         acc_q <= acc_d;
         of_q  <= of_d;
      end
   end

   assign acc = acc_q;
   assign of  = of_q;
endmodule

// File: rtl/mac_seq_ctrl.sv
// Purpose: sequences one dot-product job through mac and returns acc plus sticky overflow.
// Latency: start to first in_ready 2 cycles; last operand handshake to res_valid 2 cycles.
// Backpressure: in_ready only in RUN; result held in DONE until res_ready.
module mac_seq_ctrl
   import mac_seq_pkg::*;
#(
   parameter int LEN_W = 8,
   parameter int DW    = MAC_DW,
   parameter int AW    = MAC_AW
) (
   input  logic             clk,
   input  logic             rn,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_a,
   input  logic [DW-1:0]    in_b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [AW-1:0]    res_acc,
   output logic             res_of,
   output logic             busy
);
   state_t           state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             ovf_q, ovf_d;
   logic [AW-1:0]    res_acc_q, res_acc_d;
   logic             res_of_q, res_of_d;

   logic             hs;
   logic             mac_rst;
   logic [DW-1:0]    mac_a, mac_b;
   logic [AW-1:0]    mac_acc;
   logic             mac_of;

   assign in_ready  = (state_q == RUN);
   assign res_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign hs        = in_valid & in_ready;

   // Bubbles feed zeros so the free-running accumulator adds nothing.
   assign mac_a   = hs ? in_a : '0;
   assign mac_b   = hs ? in_b : '0;
   assign mac_rst = ~rn | (state_q == CLEAR);

   mac u_mac (
      .clk (clk),
      .rst (mac_rst),
      .a   (mac_a),
      .b   (mac_b),
      .acc (mac_acc),
      .of  (mac_of)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      ovf_d     = ovf_q;
      res_acc_d = res_acc_q;
      res_of_d  = res_of_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (len != '0) begin
                  len_d   = len;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
                  state_d = CLEAR;
               end else begin
                  res_acc_d = '0;
                  res_of_d  = 1'b0;
                  state_d   = DONE;
               end
            end
         end
         CLEAR: state_d = RUN;
         RUN: begin
            // mac of lags its add by one cycle; DRAIN picks up the final one.
            ovf_d = ovf_q | mac_of;
            if (hs) begin
               cnt_d = cnt_q + LEN_W'(1);
               if (cnt_q == len_q - LEN_W'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            res_acc_d = mac_acc;
            res_of_d  = ovf_q | mac_of;
            state_d   = DONE;
         end
         DONE: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rn) begin
      if (!rn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         len_q     <= '0;
         ovf_q     <= 1'b0;
         res_acc_q <= '0;
         res_of_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         ovf_q     <= ovf_d;
         res_acc_q <= res_acc_d;
         res_of_q  <= res_of_d;
      end
   end

   assign res_acc = res_acc_q;
   assign res_of  = res_of_q;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: job-level model (sum of products, wrap, overflow) checked every cycle.
module tb_mac_seq_ctrl;
   logic        clk;
   logic        rn;
   logic        start;
   logic [7:0]  len;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_acc;
   logic        res_of;
   logic        busy;

   mac_seq_ctrl #(.LEN_W(8)) dut (
      .clk       (clk),
      .rn        (rn),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_acc   (res_acc),
      .res_of    (res_of),
      .busy      (busy)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Job model: exact sum of accepted products; result is its low 16 bits,
   // overflow is whether the true sum ever exceeded 16 bits.
   longint m_sum = 0;
   int     m_hs = 0;
   int     m_len = 0;
   int     m_start_cyc = 0;
   int     m_last_hs = 0;
   bit     m_wait_rdy = 0;
   bit     prev_valid = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   function automatic void chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   always @(negedge clk) begin
      if (!rn) begin
         chk("rst_outputs", longint'({res_valid, in_ready, busy, res_of, res_acc}), 0);
         prev_valid = 1'b0;
      end else begin
         if (in_ready && m_wait_rdy) begin
            chk("start_to_ready", cyc - m_start_cyc, 2);
            m_wait_rdy = 1'b0;
         end
         if (in_ready) chk("ready_within_job", (m_hs < m_len) ? 1 : 0, 1);
         if (in_valid && in_ready) begin
            m_sum     += longint'(in_a) * longint'(in_b);
            m_hs++;
            m_last_hs  = cyc;
         end
         if (res_valid) begin
            chk("res_acc", res_acc, m_sum % 65536);
            chk("res_of", res_of, (m_sum >= 65536) ? 1 : 0);
            if (!prev_valid && m_len != 0) chk("hs_to_res", cyc - m_last_hs, 2);
         end
         prev_valid = res_valid;
      end
   end

   // All tasks enter and leave at posedge+1.
   task automatic start_job(input int l);
      start       = 1'b1;
      len         = 8'(l);
      m_sum       = 0;
      m_hs        = 0;
      m_len       = l;
      m_start_cyc = cyc;
      m_wait_rdy  = (l != 0);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic drive_pair(input int a, input int b, input int bub);
      int  g;
      bit  ok;
      in_valid = 1'b0;
      repeat (bub) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_a     = 8'(a);
      in_b     = 8'(b);
      g  = 0;
      ok = 1'b0;
      do begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk); #1;
         g++;
      end while (!ok && g < 64);
      if (!ok) chk("hs_timeout", ok, 1);
      in_valid = 1'b0;
   endtask

   task automatic wait_res(output logic [15:0] acc, output logic of);
      int g;
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (!res_valid && g < 400);
      if (!res_valid) chk("res_timeout", res_valid, 1);
      acc = res_acc;
      of  = res_of;
      @(posedge clk); #1;
   endtask

   int          ta[4] = '{6, 5, 9, 3};
   int          tb[4] = '{9, 4, 2, 8};
   logic [15:0] acc;
   logic        of;

   initial begin
      rn = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
      in_a = '0; in_b = '0; res_ready = 1'b1;
      #2;
      chk("reset_busy", busy, 0);
      chk("reset_res_valid", res_valid, 0);
      repeat (3) @(posedge clk);
      #1 rn = 1'b1;
      @(posedge clk); #1;

      // Continuous stream, 4 pairs.
      start_job(4);
      for (int i = 0; i < 4; i++) drive_pair(ta[i], tb[i], 0);
      wait_res(acc, of);
      chk("t1_acc", acc, 116);
      chk("t1_of", of, 0);

      // Same job with 3-cycle bubbles.
      start_job(4);
      for (int i = 0; i < 4; i++) drive_pair(ta[i], tb[i], 3);
      wait_res(acc, of);
      chk("t2_acc", acc, 116);
      chk("t2_of", of, 0);

      // Wrap with overflow, then sticky flag cleared by the next job.
      start_job(2);
      drive_pair(255, 255, 0);
      drive_pair(40, 40, 0);
      wait_res(acc, of);
      chk("t3_acc", acc, 1089);
      chk("t3_of", of, 1);
      start_job(1);
      drive_pair(2, 3, 0);
      wait_res(acc, of);
      chk("t3b_acc", acc, 6);
      chk("t3b_of", of, 0);

      // Zero-length job goes straight to DONE.
      start_job(0);
      @(negedge clk);
      chk("t4_busy_done", busy, 1);
      chk("t4_valid", res_valid, 1);
      chk("t4_acc", res_acc, 0);
      chk("t4_of", res_of, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t4_busy_idle", busy, 0);
      @(posedge clk); #1;

      // Result held under backpressure; start in DONE ignored.
      res_ready = 1'b0;
      start_job(3);
      drive_pair(10, 20, 0);
      drive_pair(30, 40, 1);
      drive_pair(1, 1, 0);
      wait_res(acc, of);
      chk("t5_acc", acc, 1401);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin start = 1'b1; len = 8'd3; end
         @(negedge clk);
         chk("t5_hold_valid", res_valid, 1);
         chk("t5_hold_acc", res_acc, 1401);
         @(posedge clk); #1;
         start = 1'b0;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("t5_idle", busy, 0);
      @(negedge clk);
      chk("t5_still_idle", busy, 0);
      @(posedge clk); #1;

      // Reset mid-job.
      start_job(4);
      drive_pair(1, 2, 0);
      drive_pair(3, 4, 0);
      rn = 1'b0;
      m_sum = 0; m_hs = 0; m_len = 0; m_wait_rdy = 1'b0;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_in_ready", in_ready, 0);
      chk("t6_res_acc", res_acc, 0);
      chk("t6_res_of", res_of, 0);
      @(posedge clk); @(posedge clk); #1;
      rn = 1'b1;
      @(posedge clk); #1;
      start_job(1);
      drive_pair(7, 7, 0);
      wait_res(acc, of);
      chk("t6_acc", acc, 49);

      // Randomized jobs, including a maximum-length one.
      for (int j = 0; j < 25; j++) begin
         int  l;
         int  mx;
         bit  rr;
         l  = (j == 10) ? 255 : $urandom_range(1, 12);
         mx = ($urandom_range(0, 1) == 1) ? 255 : 15;
         rr = 1'($urandom_range(0, 1));
         res_ready = rr;
         start_job(l);
         for (int i = 0; i < l; i++)
            drive_pair($urandom_range(0, mx), $urandom_range(0, mx),
                       ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
         wait_res(acc, of);
         if (!rr) begin
            repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
            res_ready = 1'b1;
            @(posedge clk); #1;
         end
      end

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog expired");
   end
endmodule
